// File: rtl/multicycle_control.sv
`timescale 1ns/1ps
// multicycle_control
// -----------------------------------------------------------------------------
// Main control unit for a multicycle MIPS-style datapath. A Moore FSM walks
// each instruction through fetch, decode and the opcode-specific execute and
// write-back steps. Memory steps (FETCH, MEMRD, MEMWR) stall until mem_ready.
//
// Handshake: a memory access is presented for as long as the FSM sits in a
// memory state; it completes, and the FSM advances, in the cycle mem_ready=1.
//
// Optional feature: define MULTICYCLE_JUMP_EN to add the JUMP state for
// opcode 000010. Without it, 000010 is decoded as an illegal opcode.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   Opcode[5:0]        instruction-register opcode (stable outside FETCH)
//   mem_ready          memory access completes in the cycle it is 1
//   PCWrite .. ALUSrcA single-bit datapath controls
//   ALUSrcB, ALUOp,    2-bit mux selects (ALUOp 00=add, 01=sub, 10=funct)
//   PCSource
//   illegal_op         one-cycle flag in DECODE for an unsupported opcode
//   state[3:0]         current FSM state, for debug
// -----------------------------------------------------------------------------
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
`ifdef MULTICYCLE_JUMP_EN
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
`else
    S_ADDIWB = 4'd10
`endif
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MULTICYCLE_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  state_e state_q, state_d;
  logic   dec_illegal;

  // Next-state logic. Any encoding not listed (including 11 when the jump
  // feature is absent) falls into the default arm and recovers to FETCH.
  always_comb begin
    state_d     = S_FETCH;
    dec_illegal = 1'b0;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
`ifdef MULTICYCLE_JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default: begin
            state_d     = S_FETCH;
            dec_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
`ifdef MULTICYCLE_JUMP_EN
      S_JUMP:   state_d = S_FETCH;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Output decode. Gated by rst_n so that FETCH's MemRead (and the
  // mem_ready-driven IRWrite/PCWrite) stay low for the whole reset, not just
  // after the first edge.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    illegal_op  = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB    = 2'b11;
          illegal_op = dec_illegal;
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_ALUWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        S_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_ADDIWB: begin
          RegWrite = 1'b1;
        end
`ifdef MULTICYCLE_JUMP_EN
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
`endif
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
`timescale 1ns/1ps
module tb_multicycle_control;

  // ---------------- clock / reset / DUT ----------------
  logic       clk;
  logic       rst_n;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       illegal_op;
  logic [3:0] state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .illegal_op(illegal_op), .state(state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  // The model holds the list of steps the current instruction still has to
  // visit; memory steps wait for mem_ready, others take one cycle. When
  // FETCH completes, the whole remaining route for the opcode is queued.
  int m_path[$];

  function automatic bit op_known(logic [5:0] op);
    bit k;
    k = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
        (op == 6'b000100) || (op == 6'b001000);
`ifdef MULTICYCLE_JUMP_EN
    k = k || (op == 6'b000010);
`endif
    return k;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int cur;
    if (!rst_n) begin
      m_path = '{0};
    end else begin
      cur = (m_path.size() == 0) ? 0 : m_path[0];
      if (!((cur == 0 || cur == 3 || cur == 5) && !mem_ready)) begin
        if (m_path.size() != 0) void'(m_path.pop_front());
        if (cur == 0) begin
          m_path.push_back(1);
          case (Opcode)
            6'b100011: begin m_path.push_back(2); m_path.push_back(3); m_path.push_back(4); end
            6'b101011: begin m_path.push_back(2); m_path.push_back(5); end
            6'b000000: begin m_path.push_back(6); m_path.push_back(7); end
            6'b000100: m_path.push_back(8);
            6'b001000: begin m_path.push_back(9); m_path.push_back(10); end
`ifdef MULTICYCLE_JUMP_EN
            6'b000010: m_path.push_back(11);
`endif
            default: ;
          endcase
        end
        if (m_path.size() == 0) m_path.push_back(0);
      end
    end
  end

  // Output vector order:
  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
  //  RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,illegal_op,state}
  function automatic logic [20:0] exp_vec(int st, logic mr, logic [5:0] op, logic in_rst);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill;
    logic [1:0] asb, aop, pcs;
    logic [3:0] s4;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    s4 = st[3:0];
    if (in_rst) s4 = 4'd0;
    else begin
      case (st)
        0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
        1:  begin asb = 2'b11; ill = !op_known(op); end
        2:  begin asa = 1; asb = 2'b10; end
        3:  begin mrd = 1; iord = 1; end
        4:  begin m2r = 1; rw = 1; end
        5:  begin mwr = 1; iord = 1; end
        6:  begin asa = 1; aop = 2'b10; end
        7:  begin rdst = 1; rw = 1; end
        8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
        9:  begin asa = 1; asb = 2'b10; end
        10: begin rw = 1; end
        11: begin pcw = 1; pcs = 2'b10; end
        default: ;
      endcase
    end
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, ill, s4};
  endfunction

  function automatic logic [20:0] dut_vec();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
            RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, state};
  endfunction

  // ---------------- per-cycle compare ----------------
  logic       trace_en = 1'b0;
  logic [3:0] trace_q[$];

  always @(negedge clk) begin
    logic [20:0] e, a;
    int st;
    st = (m_path.size() == 0) ? 0 : m_path[0];
    e  = exp_vec(st, mem_ready, Opcode, !rst_n);
    a  = dut_vec();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL outputs t=%0t model_state=%0d got=%h exp=%h", $time, st, a, e);
    end
    checks++;
    if ((int'(RegWrite) + int'(MemWrite) + int'(PCWrite)) > 1) begin
      errors++;
      $display("FAIL write_exclusive t=%0t RegWrite=%b MemWrite=%b PCWrite=%b exp at most one",
               $time, RegWrite, MemWrite, PCWrite);
    end
    if (trace_en) trace_q.push_back(state);
  end

  // ---------------- driver tasks ----------------
  logic [3:0] exp_q[$];   // hand-computed state trace
  logic       mr_q[$];    // mem_ready per cycle

  // Starts with the DUT in FETCH; runs one cycle per mr_q entry, then
  // compares the captured state trace with exp_q.
  task automatic run_instr(input logic [5:0] op, input string name);
    Opcode   = op;
    trace_q.delete();
    trace_en = 1'b1;
    for (int i = 0; i < mr_q.size(); i++) begin
      mem_ready = mr_q[i];
      @(posedge clk);
      #2;
    end
    trace_en = 1'b0;
    checks++;
    if (trace_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_len got=%0d exp=%0d", name, trace_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (trace_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s_state[%0d] got=%0d exp=%0d", name, i, trace_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic check_val(input string name, input logic [20:0] got, input logic [20:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [5:0] op_list [0:6];

  initial begin
    op_list = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                6'b001000, 6'b000010, 6'b111111};
    Opcode = 6'b000000; mem_ready = 1'b0; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #2;
    // first edge after release evaluates FETCH: mem_ready=0 holds it there
    check_val("post_reset_fetch", {17'd0, state}, 21'd0);
    check_val("post_reset_memread", {20'd0, MemRead}, 21'd1);

    // R-type
    exp_q = '{0, 1, 6, 7};            mr_q = '{1, 1, 1, 1};
    run_instr(6'b000000, "rtype");
    // R-type with two FETCH stall cycles
    exp_q = '{0, 0, 0, 1, 6, 7};      mr_q = '{0, 0, 1, 1, 1, 1};
    run_instr(6'b000000, "rtype_stall");
    // lw with two MEMRD stall cycles
    exp_q = '{0, 1, 2, 3, 3, 3, 4};   mr_q = '{1, 1, 1, 0, 0, 1, 1};
    run_instr(6'b100011, "lw_stall");
    // lw no stalls: 5 cycles
    exp_q = '{0, 1, 2, 3, 4};         mr_q = '{1, 1, 1, 1, 1};
    run_instr(6'b100011, "lw");
    // sw
    exp_q = '{0, 1, 2, 5};            mr_q = '{1, 1, 1, 1};
    run_instr(6'b101011, "sw");
    // sw with MEMWR stall
    exp_q = '{0, 1, 2, 5, 5};         mr_q = '{1, 1, 1, 0, 1};
    run_instr(6'b101011, "sw_stall");
    // beq
    exp_q = '{0, 1, 8};               mr_q = '{1, 1, 1};
    run_instr(6'b000100, "beq");
    // addi
    exp_q = '{0, 1, 9, 10};           mr_q = '{1, 1, 1, 1};
    run_instr(6'b001000, "addi");
    // jump opcode
`ifdef MULTICYCLE_JUMP_EN
    exp_q = '{0, 1, 11};              mr_q = '{1, 1, 1};
`else
    exp_q = '{0, 1};                  mr_q = '{1, 1};
`endif
    run_instr(6'b000010, "jump");
    // illegal opcode
    exp_q = '{0, 1};                  mr_q = '{1, 1};
    run_instr(6'b111111, "illegal");

    // reset in the middle of a stalled store
    Opcode = 6'b101011; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 mem_ready = 1'b0;
    @(posedge clk); #2;
    check_val("memwr_before_reset", {16'd0, MemWrite, state}, {16'd0, 1'b1, 4'd5});
    #1 rst_n = 1'b0;
    #1 check_val("async_reset_outputs", dut_vec(), 21'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    exp_q = '{0, 1, 6, 7};            mr_q = '{1, 1, 1, 1};
    run_instr(6'b000000, "after_reset");

    // mixed traffic, opcode changed only while the model sits in FETCH
    for (int c = 0; c < 300; c++) begin
      if (m_path.size() != 0 && m_path[0] == 0)
        Opcode = op_list[$urandom_range(0, 6)];
      mem_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #2;
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
